spike_time_decoder: RTL and testbench
=====================================

Name: spike_time_decoder

Overview:
- Downstream consumer of the temporal min/race-logic stages. Converts a rising-edge-coded spike on a single line into a binary arrival time, measured in aclk cycles from the gamma-cycle start.
- Results are queued in a small FIFO and presented on a valid/ready interface to the binary-domain readout logic.
- A line with no edge inside the gamma cycle yields the "infinity" code.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (>=2).
- VALUE_WIDTH, $clog2(GAMMA_CYCLE_WIDTH)+1, result width; wide enough to hold GAMMA_CYCLE_WIDTH (the infinity code).
- FIFO_DEPTH, 2, result queue entries (power of two, >=2).

Ports:
- aclk  input  1  clock.
- grst_n  input  1  reset, asynchronous assert, active-low.
- gamma_start  input  1  one-cycle pulse marking time 0 of a gamma cycle (same pulse that drives set on upstream stages).
- spike_in  input  1  aclk-synchronous spike line; rising-edge coded, low at gamma start.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- out_time  output  VALUE_WIDTH  arrival time of head entry.
- out_no_spike  output  1  head entry is the infinity code.
- overflow  output  1  sticky: a result was dropped because the FIFO was full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (grst_n low, any time, including mid-cycle):
  - state=IDLE, cnt=0, spike_prev=0, FIFO emptied.
  - out_valid=0, out_time=0, out_no_spike=0, overflow=0.
- Registers:
  - cnt is VALUE_WIDTH bits.
  - spike_prev holds spike_in from the previous cycle.
  - edge = spike_in & ~spike_prev.
- States:
  - IDLE:
    - gamma_start -> ARMED, cnt=0. If edge also holds in that same cycle, capture time 0 and go to DONE.
    - Edges are ignored.
  - ARMED: cnt increments each cycle.
    - edge at cnt=k -> push {time=k, no_spike=0}, go DONE.
    - cnt==GAMMA_CYCLE_WIDTH-1 with no edge -> push {time=GAMMA_CYCLE_WIDTH, no_spike=1}, go IDLE.
  - DONE: further edges ignored (first spike only). cnt keeps counting; cnt==GAMMA_CYCLE_WIDTH-1 -> IDLE.
- gamma_start in ARMED or DONE restarts the cycle:
  - cnt=0, state ARMED; no result is pushed for the aborted cycle.
  - An edge in the same cycle as gamma_start belongs to the new cycle and has time 0 (go DONE, push 0).
- Timing:
  - The gamma_start cycle is time 0.
  - A push in cycle N makes the entry visible at the FIFO output in cycle N+1 (1-cycle latency).
- FIFO:
  - Registered outputs; pop on out_valid & out_ready.
  - Simultaneous push and pop when full: pop then push; no drop.
  - Push when full with no pop: result dropped, overflow<=1.
  - overflow_clr and a new drop in the same cycle: overflow stays 1.
  - out_time and out_no_spike hold stable while out_valid & ~out_ready.
  - When empty, out_time and out_no_spike are driven 0.
- Arithmetic: cnt never exceeds GAMMA_CYCLE_WIDTH-1 in counting states. The infinity code GAMMA_CYCLE_WIDTH (16 -> 5'b10000) is a constant, not a count.

Test Plan:
- Reset, then gamma_start at cycle 0, spike_in rises at cycle 5, out_ready=1 -> out_valid high at cycle 6, out_time=5, out_no_spike=0; single entry only.
- gamma_start and spike_in rise in the same cycle -> out_time=0, no_spike=0. A second edge at cycle 3 (after a drop to low) produces no entry.
- gamma_start, spike_in stays low for 16 cycles -> one entry with out_time=16, out_no_spike=1, pushed at cnt=15; state returns to IDLE.
- out_ready=0, three gamma cycles with spikes at 2, 7, 9 -> FIFO holds 2 and 7, overflow=1. Raise out_ready -> pops 2 then 7. Pulse overflow_clr -> overflow=0.
- gamma_start re-pulsed at cnt=4 with no spike yet, spike at 3 cycles later -> only entry is out_time=3.
- grst_n low mid-cycle while FIFO holds 1 entry and state is ARMED -> out_valid=0 immediately (async), overflow=0. After release, no result until the next gamma_start.

Source files
------------

// File: rtl/spike_time_decoder.sv
// spike_time_decoder
//   Converts the first rising edge on a rising-edge-coded spike line into its
//   arrival time, in aclk cycles counted from gamma_start (time 0). A gamma
//   cycle with no edge yields the infinity code GAMMA_CYCLE_WIDTH with
//   no_spike set. Results are queued in a small FIFO and handed out on a
//   valid/ready interface.
//
// Ports
//   aclk          clock
//   grst_n        asynchronous active-low reset
//   gamma_start   one-cycle pulse marking time 0 of a gamma cycle
//   spike_in      aclk-synchronous spike line, rising-edge coded
//   out_valid     FIFO head valid
//   out_ready     consumer accepts head when out_valid & out_ready
//   out_time      arrival time of head entry (0 when empty)
//   out_no_spike  head entry is the infinity code (0 when empty)
//   overflow      sticky: a result was dropped because the FIFO was full
//   overflow_clr  clears overflow (a same-cycle drop wins)
module spike_time_decoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  parameter int FIFO_DEPTH        = 2
) (
  input  logic                   aclk,
  input  logic                   grst_n,
  input  logic                   gamma_start,
  input  logic                   spike_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VALUE_WIDTH-1:0] out_time,
  output logic                   out_no_spike,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [VALUE_WIDTH-1:0] LAST_CNT  = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VALUE_WIDTH-1:0] INF_CODE  = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH);
  localparam logic [VALUE_WIDTH-1:0] FIRST_CNT = VALUE_WIDTH'(1);
  localparam logic [LVL_W-1:0]       FULL_LVL  = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [VALUE_WIDTH-1:0] cnt_q, cnt_d;
  logic                   spike_prev_q;
  logic                   spike_edge;

  logic                   push;
  logic [VALUE_WIDTH-1:0] push_time;
  logic                   push_ns;

  logic [VALUE_WIDTH-1:0] time_mem_q [FIFO_DEPTH];
  logic                   ns_mem_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   pop, full, wr_en, drop;

  assign spike_edge = spike_in & ~spike_prev_q;

  // cnt_q holds the time of the current cycle; the gamma_start cycle is
  // time 0, so the first counting cycle after it is loaded with 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_time = '0;
    push_ns   = 1'b0;
    if (gamma_start) begin
      // Restart has priority; an aborted cycle produces no result, and an
      // edge coincident with gamma_start is time 0 of the new cycle.
      cnt_d = FIRST_CNT;
      if (spike_edge) begin
        state_d = S_DONE;
        push    = 1'b1;
      end else begin
        state_d = S_ARMED;
      end
    end else begin
      case (state_q)
        S_ARMED: begin
          if (spike_edge) begin
            push      = 1'b1;
            push_time = cnt_q;
          end else if (cnt_q == LAST_CNT) begin
            push      = 1'b1;
            push_time = INF_CODE;
            push_ns   = 1'b1;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = spike_edge ? S_DONE : S_ARMED;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IDLE: ;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      spike_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      spike_prev_q <= spike_in;
    end
  end

  // Result FIFO. A pop frees a slot in the same cycle, so push+pop when full
  // is accepted rather than dropped.
  assign pop   = (level_q != '0) & out_ready;
  assign full  = (level_q == FULL_LVL);
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  assign overflow_d = drop | (overflow_q & ~overflow_clr);

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      time_mem_q[wr_ptr_q] <= push_time;
      ns_mem_q[wr_ptr_q]   <= push_ns;
    end
  end

  assign out_valid    = (level_q != '0);
  assign out_time     = out_valid ? time_mem_q[rd_ptr_q] : '0;
  assign out_no_spike = out_valid ? ns_mem_q[rd_ptr_q] : 1'b0;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_spike_time_decoder.sv
module tb_spike_time_decoder;

  localparam int W     = 16;
  localparam int VW    = 5;
  localparam int DEPTH = 2;

  logic          aclk = 1'b0;
  logic          grst_n;
  logic          gamma_start;
  logic          spike_in;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_time;
  logic          out_no_spike;
  logic          overflow;
  logic          overflow_clr;

  int total = 0;
  int bad   = 0;

  // Reference model: a gamma window opened at absolute cycle win_start;
  // the result is (first rise cycle - win_start), or W if the window closes
  // without a rise. exp_q is the expected FIFO content, head first.
  int exp_q[$];
  int win_start;
  bit captured;
  bit prev_sp;
  bit ovf_m;
  int cyc;

  spike_time_decoder #(
    .GAMMA_CYCLE_WIDTH(W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk),
    .grst_n(grst_n),
    .gamma_start(gamma_start),
    .spike_in(spike_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_time(out_time),
    .out_no_spike(out_no_spike),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 aclk = ~aclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic xchk(input string tag, input int v, input int t, input int ns);
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_time"}, out_time, t);
    chk({tag, "_no_spike"}, out_no_spike, ns);
  endtask

  task automatic model_reset();
    exp_q.delete();
    win_start = -1;
    captured  = 1'b0;
    prev_sp   = 1'b0;
    ovf_m     = 1'b0;
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    chk("valid", out_valid, (n > 0) ? 1 : 0);
    chk("time", out_time, (n > 0) ? exp_q[0] : 0);
    chk("no_spike", out_no_spike, (n > 0 && exp_q[0] == W) ? 1 : 0);
    chk("overflow", overflow, ovf_m);
  endtask

  task automatic model_step();
    bit rise;
    bit push_v;
    int push_t;
    bit drop;
    int t;
    rise   = spike_in && !prev_sp;
    push_v = 1'b0;
    push_t = 0;
    drop   = 1'b0;
    if (gamma_start) begin
      win_start = cyc;
      captured  = 1'b0;
    end
    if (win_start >= 0) begin
      t = cyc - win_start;
      if (rise && !captured) begin
        push_v   = 1'b1;
        push_t   = t;
        captured = 1'b1;
      end
      if (t == W - 1) begin
        if (!captured) begin
          push_v = 1'b1;
          push_t = W;
        end
        win_start = -1;
      end
    end
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (push_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(push_t);
      else drop = 1'b1;
    end
    ovf_m   = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_m);
    prev_sp = spike_in;
    cyc++;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic step(input bit gs, input bit sp, input bit rdy, input bit clr);
    gamma_start  = gs;
    spike_in     = sp;
    out_ready    = rdy;
    overflow_clr = clr;
    @(negedge aclk);
    check_outputs();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    bit sp_r;
    int ks[3];
    grst_n       = 1'b0;
    gamma_start  = 1'b0;
    spike_in     = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    cyc          = 0;
    sp_r         = 1'b0;
    ks[0] = 2; ks[1] = 7; ks[2] = 9;
    model_reset();

    repeat (3) @(posedge aclk);
    #1;
    xchk("reset", 0, 0, 0);
    chk("reset_overflow", overflow, 0);
    @(negedge aclk);
    grst_n = 1'b1;
    @(posedge aclk);
    #1;

    // Spike at time 5.
    step(1, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    xchk("t5", 1, 5, 0);
    step(0, 1, 1, 0);
    chk("t5_single", out_valid, 0);
    repeat (12) step(0, 0, 1, 0);

    // Edge coincident with gamma_start, later re-edge ignored.
    step(1, 1, 1, 0);
    xchk("t0", 1, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("second_edge_ignored", out_valid, 0);
    repeat (14) step(0, 0, 1, 0);

    // No spike: infinity code pushed in the last cycle of the window.
    step(1, 0, 1, 0);
    repeat (14) step(0, 0, 1, 0);
    chk("inf_not_early", out_valid, 0);
    step(0, 0, 1, 0);
    xchk("inf", 1, 16, 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("idle_edge_ignored", out_valid, 0);

    // Fill with ready low: 2 and 7 kept, 9 dropped.
    foreach (ks[j]) begin
      step(1, 0, 0, 0);
      for (int i = 1; i < W; i++) step(0, (i >= ks[j]), 0, 0);
    end
    chk("ovf_set", overflow, 1);
    xchk("fifo_head0", 1, 2, 0);
    step(0, 0, 1, 0);
    xchk("fifo_head1", 1, 7, 0);
    step(0, 0, 1, 0);
    chk("fifo_drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    step(0, 0, 0, 1);
    chk("ovf_cleared", overflow, 0);

    // Restart at time 4, spike 3 cycles into the new window.
    step(1, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    xchk("restart", 1, 3, 0);
    repeat (16) step(0, 0, 1, 0);
    chk("restart_single", out_valid, 0);

    // Async reset while one entry is queued, overflow set, state ARMED.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    xchk("pre_reset", 1, 1, 0);
    chk("pre_reset_ovf", overflow, 1);
    #2;
    grst_n = 1'b0;
    #1;
    xchk("async_reset", 0, 0, 0);
    chk("async_reset_ovf", overflow, 0);
    model_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    grst_n = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 20; i++) step(0, (i % 3 == 1), 1, 0);
    chk("post_reset_quiet", out_valid, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) sp_r = ~sp_r;
      step(($urandom_range(0, 19) == 0), sp_r, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0));
    end
    repeat (4) step(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
